// File: rtl/rv32_fetch_queue.sv
// rv32_fetch_queue
//   Instruction-fetch front end for the RV32I pipeline. Issues word fetches to
//   an instruction memory with variable, in-order response latency, buffers
//   the returned instructions together with their PC in a small FIFO, and
//   hands them to the IF/ID register over a valid/ready handshake. A redirect
//   from EX flushes the FIFO and squashes every response still in flight.
//
// Ports
//   clk, rst          clock (rising edge) / asynchronous active-high reset
//   redirect_valid/pc EX redirect request and target (bits [1:0] ignored)
//   imem_req_*        fetch request channel (valid/ready, word address)
//   imem_rsp_*        fetch response channel (valid + instruction word)
//   if_valid/ready    delivery handshake towards IF/ID
//   if_pc/if_inst     head entry (0 / NOP_INST when the FIFO is empty)
module rv32_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;

  logic [31:0] pc_mem_q   [QUEUE_DEPTH];
  logic [31:0] inst_mem_q [QUEUE_DEPTH];

  logic        req_fire;
  logic        rsp_drop;
  logic        push;
  logic        pop;
  logic [CW:0] inflight;
  logic [31:0] target_pc;
  logic [1:0]  unused_rpc_lo;

  assign unused_rpc_lo = redirect_pc[1:0];
  assign target_pc     = {redirect_pc[31:2], 2'b00};

  // Credit check: buffered + outstanding never exceeds the FIFO size, so a
  // response always has a free slot waiting for it.
  assign inflight       = {1'b0, count_q} + {1'b0, out_q};
  assign imem_req_valid = !rst && !redirect_valid && (inflight < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses belonging to squashed requests are discarded, including the
  // one that lands in the redirect cycle itself.
  assign rsp_drop = imem_rsp_valid && ((drop_q != '0) || redirect_valid);
  assign push     = imem_rsp_valid && !rsp_drop;

  assign if_valid = (count_q != '0);
  assign pop      = if_valid && if_ready;
  assign if_pc    = if_valid ? pc_mem_q[rd_q]   : 32'h0;
  assign if_inst  = if_valid ? inst_mem_q[rd_q] : NOP_INST;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    out_d    = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d   = drop_q;
    rd_d     = pop  ? rd_q + AW'(1) : rd_q;
    wr_d     = push ? wr_q + AW'(1) : wr_q;
    if (req_fire) pc_d = pc_q + 32'd4;
    if (push) rsp_pc_d = rsp_pc_q + 32'd4;
    if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    // Redirect wins over everything: every request still outstanding after
    // this cycle's updates belongs to the old path and must be dropped.
    if (redirect_valid) begin
      pc_d     = target_pc;
      rsp_pc_d = target_pc;
      count_d  = '0;
      rd_d     = '0;
      wr_d     = '0;
      drop_d   = out_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      count_q  <= '0;
      out_q    <= '0;
      drop_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      count_q  <= count_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  // FIFO storage holds data only; validity is carried by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_q]   <= rsp_pc_q;
      inst_mem_q[wr_q] <= imem_rsp_data;
    end
  end

endmodule
